// File: rtl/encoder_pkg.sv
// Shared types and the priority-encode rule for the 4-to-2 encoder block.
// The encode function is pure combinational; storage lives in the FIFO.
package encoder_pkg;

    localparam int IDX_W = 2;
    localparam int IN_W  = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             zero;
        logic             multi;
    } entry_t;

    // Highest set bit wins; clearing the lowest set bit detects multi-hot.
    function automatic entry_t prio_enc4(input logic [IN_W-1:0] d);
        entry_t           e;
        logic [IN_W-1:0]  d_low_cleared;
        d_low_cleared = d & (d - IN_W'(1));
        e.idx   = '0;
        e.zero  = (d == '0);
        e.multi = (d_low_cleared != '0);
        if (d[3])      e.idx = 2'd3;
        else if (d[2]) e.idx = 2'd2;
        else if (d[1]) e.idx = 2'd1;
        else           e.idx = 2'd0;
        return e;
    endfunction

endpackage

// File: rtl/encoder4to2_if.sv
// Handshake bundle for the encoder: input word side, result side and error count.
// slave is the encoder's view, master is the driver/consumer's view.
interface encoder4to2_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       D;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       A;
    logic             zero;
    logic             multi;
    logic [CNT_W-1:0] err_cnt;

    modport slave (
        input  in_valid, D, out_ready,
        output in_ready, out_valid, A, zero, multi, err_cnt
    );

    modport master (
        output in_valid, D, out_ready,
        input  in_ready, out_valid, A, zero, multi, err_cnt
    );
endinterface

// File: rtl/enc_fifo2.sv
// Generic 2-entry FIFO; head is always slot0, so dout is a plain register.
// Push is refused when FULL and pop when EMPTY; full/empty come from state only.
module enc_fifo2
    import encoder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    fifo_state_t  state_q;
    logic [W-1:0] slot0_q;
    logic [W-1:0] slot1_q;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (state_q != FULL);
    assign do_pop  = pop  && (state_q != EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (do_push) begin
                        slot0_q <= din;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    // Simultaneous push/pop replaces the head in place.
                    if (do_push && do_pop) begin
                        slot0_q <= din;
                    end else if (do_push) begin
                        slot1_q <= din;
                        state_q <= FULL;
                    end else if (do_pop) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (do_pop) begin
                        slot0_q <= slot1_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign dout  = slot0_q;
    assign full  = (state_q == FULL);
    assign empty = (state_q == EMPTY);
endmodule

// File: rtl/encoder4to2.sv
// Registered 4-to-2 priority encoder with saturating non-one-hot counter; 1-cycle latency.
// 2-entry buffer absorbs back-pressure; in_ready depends only on buffer state.
module encoder4to2
    import encoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    encoder4to2_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t           enc;
    entry_t           head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] cnt_q;

    assign enc  = prio_enc4(bus.D);
    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    enc_fifo2 #(
        .W ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (enc),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push && (enc.zero || enc.multi) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.A         = head.idx;
    assign bus.zero      = head.zero;
    assign bus.multi     = head.multi;
    assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_encoder4to2.sv
// Bench for encoder4to2: directed scenarios then random traffic against a queue model.
// A second instance with a 2-bit counter runs the same stimulus to exercise saturation.
module tb_encoder4to2;

    typedef struct {
        logic [1:0] a;
        logic       z;
        logic       m;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    encoder4to2_if #(.CNT_W(8)) bus ();
    encoder4to2_if #(.CNT_W(2)) bus2 ();

    encoder4to2 #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    encoder4to2 #(.CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    int   cnt_ref  = 0;
    int   cnt2_ref = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_enc(input logic [3:0] d);
        exp_t e;
        e.a = 2'd0;
        for (int i = 0; i < 4; i++)
            if (d[i]) e.a = 2'(i);
        e.z = (d == 4'd0);
        e.m = ($countones(d) >= 2);
        return e;
    endfunction

    task automatic check_outputs();
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("A", 32'(bus.A), 32'(q[0].a));
            chk("zero", 32'(bus.zero), 32'(q[0].z));
            chk("multi", 32'(bus.multi), 32'(q[0].m));
        end
        chk("err_cnt", 32'(bus.err_cnt), 32'(cnt_ref));
        chk("err_cnt_sat", 32'(bus2.err_cnt), 32'(cnt2_ref));
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic v, input logic [3:0] d, input logic ordy);
        logic mpush;
        logic mpop;
        exp_t e;
        bus.in_valid   = v;
        bus.D          = d;
        bus.out_ready  = ordy;
        bus2.in_valid  = v;
        bus2.D         = d;
        bus2.out_ready = ordy;
        mpush = v && (q.size() < 2);
        mpop  = ordy && (q.size() > 0);
        @(posedge clk);
        if (mpop) void'(q.pop_front());
        if (mpush) begin
            e = ref_enc(d);
            q.push_back(e);
            if (e.z || e.m) begin
                if (cnt_ref < 255) cnt_ref++;
                if (cnt2_ref < 3) cnt2_ref++;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_A"}, 32'(bus.A), 32'd0);
        chk({tag, "_zero"}, 32'(bus.zero), 32'd0);
        chk({tag, "_multi"}, 32'(bus.multi), 32'd0);
        chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'd0);
        chk({tag, "_err_cnt_sat"}, 32'(bus2.err_cnt), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.D          = 4'd0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.D         = 4'd0;
        bus2.out_ready = 1'b0;

        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // One-hot sweep
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0010, 1'b1);
        step(1'b1, 4'b0100, 1'b1);
        step(1'b1, 4'b1000, 1'b1);
        step(1'b0, 4'b1111, 1'b1);

        // Illegal codes
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0110, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        chk("illegal_err_cnt", 32'(bus.err_cnt), 32'd2);

        // Back-pressure: third word waits until space frees up
        step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        // Streaming in state ONE
        step(1'b1, 4'b0010, 1'b1);
        for (int i = 0; i < 10; i++)
            step(1'b1, 4'($urandom), 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        // Reset with two entries buffered
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b1100, 1'b0);
        #2 rst = 1'b1;
        #1;
        q.delete();
        cnt_ref  = 0;
        cnt2_ref = 0;
        check_reset_state("midrst");
        bus.in_valid  = 1'b1;
        bus2.in_valid = 1'b1;
        @(negedge clk);
        check_reset_state("rst_held");
        rst = 1'b0;
        step(1'b0, 4'b0000, 1'b1);

        // Saturation on the narrow counter
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        chk("sat_final", 32'(bus2.err_cnt), 32'd3);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/encoder4to2.md
# encoder4to2

Registered 4-to-2 priority encoder with a valid/ready handshake on both sides. It is the inverse of the team's 2-to-4 decoder: it turns a 4-bit one-hot (or multi-hot) word back into a 2-bit index. A 2-entry output buffer absorbs downstream back-pressure. A saturating counter tracks non-one-hot inputs.

## Interface
Parameters:
- CNT_W, 8, width of the error counter `err_cnt`.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  `D` holds a word to encode.
- in_ready  output  1  the block can accept a word this cycle.
- D  input  4  word to encode.
- out_valid  output  1  `A`, `zero` and `multi` hold a result.
- out_ready  input  1  downstream consumes the result this cycle.
- A  output  2  encoded index.
- zero  output  1  the source word was 4'b0000.
- multi  output  1  the source word had more than one bit set.
- err_cnt  output  CNT_W  number of accepted words that were not one-hot; saturates.

## Operation
- Accept: a word is accepted on a rising edge when `in_valid && in_ready`.
- Encode rule (highest index wins): `A` = index of the highest set bit in `D`.
  - D=0000 → A=00, zero=1.
  - multi = 1 when popcount(D) ≥ 2, e.g. D=1010 → A=11, multi=1.
  - Encoding is combinational from `D`. Only the result {A, zero, multi} is stored.
- Buffer: 2-entry FIFO of 4-bit entries {A, zero, multi}.
  - State is the occupancy count: EMPTY(0), ONE(1), FULL(2).
  - push = `in_valid && in_ready`.
  - pop = `out_valid && out_ready`.
- Transitions:
  - EMPTY: push → ONE.
  - ONE: push without pop → FULL; pop without push → EMPTY; push and pop together → ONE.
  - FULL: pop → ONE. No push is possible in FULL.
- Ordering: results leave in strict acceptance order.
- Flow-control signals:
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
  - Outputs always present the oldest entry.
- Error counter: on each push with zero or multi set, `err_cnt` increments.
  - Holds at 2^CNT_W−1 once reached; it never wraps.
  - The counter clears only on reset.
- Handshake rules:
  - While `out_valid && !out_ready`, A/zero/multi stay stable.
  - `D` is ignored when `in_valid` = 0.
  - `in_valid` may drop without a handshake. No input is stored unless it is accepted.

## Timing
- Reset (async assert, sync-to-clk deassert at the source):
  - State returns to EMPTY.
  - out_valid=0, A=00, zero=0, multi=0, err_cnt=0.
  - in_ready=1.
  - Pushes are ignored while rst=1.
- Reset mid-operation: all buffered entries are discarded immediately. Nothing is replayed after reset.
- Latency: a word accepted at edge N appears with out_valid=1 in the cycle after edge N. There is no combinational in→out bypass.
- Throughput: one word per cycle with out_ready held high (state stays ONE).
- Simultaneous push and pop:
  - In ONE: the pop removes the current head and the new entry becomes the head after the edge.
  - In EMPTY: a pop cannot occur.
- Timing of `err_cnt`: updates on the same edge as the accepting push.
- Combinational paths: `in_ready` depends only on registered state, with no path from `out_ready`.

## Structure
- Package `encoder_pkg`:
  - IDX_W=2 and IN_W=4.
  - State enum {EMPTY, ONE, FULL}.
  - Entry struct {idx, zero, multi}.
  - Pure function `prio_enc4` covering the encode rule.
- Sub-module `enc_fifo2`: generic 2-entry synchronous FIFO with push/pop, full/empty and the async active-high reset.
  - The top level holds the encoder function, the error counter and the wiring.

## Test plan
- Reset: assert rst mid-stream with 2 entries buffered → out_valid=0, A=00, err_cnt=0, in_ready=1 immediately; the old entries never appear.
- One-hot sweep: D=0001, 0010, 0100, 1000 with out_ready=1 → A=00, 01, 10, 11 each one cycle later; zero=0, multi=0, err_cnt=0.
- Illegal codes: D=0000 then D=0110 → (A=00, zero=1) then (A=10, multi=1); err_cnt=2.
- Back-pressure: out_ready=0 while pushing 1000, 0001, 0100 → in_ready drops after 2 accepts and the third word waits. Releasing out_ready yields A=11, 00, 10 in order, with outputs stable while stalled.
- Simultaneous push/pop: hold state ONE with in_valid=1, out_ready=1 for 10 cycles → one result per cycle and the state stays ONE.
- Saturation: CNT_W=2, push 5 zero words → err_cnt reads 1, 2, 3, 3, 3.
